alu_serial_param: RTL and testbench

Parametrised, digit-serial successor to the fixed 16-bit ripple ALU. It processes a WIDTH-bit operation SLICE bits per clock and carries between slices in a register, trading latency for a short critical path. It keeps the existing Ainvert/Binvert/Operation/carry_in control model and adds set-less-than, overflow and zero flags. Operands and results move through valid/ready handshakes. It sits between the register-file read stage and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_slice.sv | 49 ++++
 rtl/alu_serial_param.sv | 190 +++++++++++++++++++
 tb/tb_alu_serial_param.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU.
// Holds the Operation encodings, the control FSM state type and a small
// helper that tells whether an operation uses the adder path.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    // ADD and SLT share the adder and the carry chain; AND and OR do not.
    function automatic logic isArith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice.
// Ports:
//   a, b        slice of the latched operands
//   Ainvert     invert a before the operation
//   Binvert     invert b before the operation
//   Operation   AND / OR / ADD / SLT selector
//   cin         carry into bit 0 of the slice
//   res         slice result (sum for ADD and SLT)
//   cout        carry out of the slice MSB
//   msb_cin     carry into the slice MSB, used for signed overflow
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             Ainvert,
    input  logic             Binvert,
    input  logic [1:0]       Operation,
    input  logic             cin,
    output logic [SLICE-1:0] res,
    output logic             cout,
    output logic             msb_cin
);

    logic [SLICE-1:0] aEff;
    logic [SLICE-1:0] bEff;
    logic [SLICE-1:0] sum;

    assign aEff = a ^ {SLICE{Ainvert}};
    assign bEff = b ^ {SLICE{Binvert}};

    assign {cout, sum} = {1'b0, aEff} + {1'b0, bEff} + {{SLICE{1'b0}}, cin};

    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
    // of the sum without a second adder.
    assign msb_cin = sum[SLICE-1] ^ aEff[SLICE-1] ^ bEff[SLICE-1];

    always_comb begin
        res = sum;
        case (Operation)
            OP_AND:  res = aEff & bEff;
            OP_OR:   res = aEff | bEff;
            default: res = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_param.sv
// Digit-serial ALU: processes a WIDTH-bit operation SLICE bits per clock,
// keeping the inter-slice carry in a register so the critical path is one
// SLICE-bit ripple regardless of WIDTH.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   operandA, operandB    operands
//   Ainvert, Binvert      invert operands before the operation
//   Operation             00 AND, 01 OR, 10 ADD, 11 SLT
//   carry_in              carry into bit 0
//   out_valid / out_ready result handshake
//   out                   result
//   carry_out, overflow   adder flags (zero for logic ops)
//   isZero                out == 0
// WIDTH must be a multiple of SLICE.
module alu_serial_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             Ainvert,
    input  logic             Binvert,
    input  logic [1:0]       Operation,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             isZero
);

    localparam int N = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] aOp_q, aOp_d;
    logic [WIDTH-1:0] bOp_q, bOp_d;
    logic             aInv_q, aInv_d;
    logic             bInv_q, bInv_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryOut_q, carryOut_d;
    logic             overflow_q, overflow_d;
    logic             isZero_q, isZero_d;

    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] sliceRes;
    logic             sliceCout;
    logic             sliceMsbCin;
    logic             sliceOvf;

    // Slice-select mux: the slice index picks the operand bits to feed the
    // single shared slice each BUSY cycle.
    assign sliceA = aOp_q[int'(idx_q) * SLICE +: SLICE];
    assign sliceB = bOp_q[int'(idx_q) * SLICE +: SLICE];

    alu_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a        (sliceA),
        .b        (sliceB),
        .Ainvert  (aInv_q),
        .Binvert  (bInv_q),
        .Operation(op_q),
        .cin      (carry_q),
        .res      (sliceRes),
        .cout     (sliceCout),
        .msb_cin  (sliceMsbCin)
    );

    // Only meaningful on the last slice, where the slice MSB is the word MSB.
    assign sliceOvf = sliceMsbCin ^ sliceCout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            aOp_q      <= '0;
            bOp_q      <= '0;
            aInv_q     <= 1'b0;
            bInv_q     <= 1'b0;
            op_q       <= OP_AND;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
            isZero_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            aOp_q      <= aOp_d;
            bOp_q      <= bOp_d;
            aInv_q     <= aInv_d;
            bInv_q     <= bInv_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
            isZero_q   <= isZero_d;
        end
    end

    // Flags are computed on the last BUSY cycle and then held through DONE.
    // For SLT the written sum slices are replaced by the single
    // overflow-corrected sign bit at that point.
    always_comb begin
        state_d    = state_q;
        aOp_d      = aOp_q;
        bOp_d      = bOp_q;
        aInv_d     = aInv_q;
        bInv_d     = bInv_q;
        op_d       = op_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        result_d   = result_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;
        isZero_d   = isZero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aOp_d      = operandA;
                    bOp_d      = operandB;
                    aInv_d     = Ainvert;
                    bInv_d     = Binvert;
                    op_d       = Operation;
                    carry_d    = carry_in;
                    idx_d      = '0;
                    result_d   = '0;
                    carryOut_d = 1'b0;
                    overflow_d = 1'b0;
                    isZero_d   = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                result_d[int'(idx_q) * SLICE +: SLICE] = sliceRes;
                if (isArith(op_q)) begin
                    carry_d = sliceCout;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    if (isArith(op_q)) begin
                        carryOut_d = sliceCout;
                        overflow_d = sliceOvf;
                        if (op_q == OP_SLT) begin
                            result_d    = '0;
                            result_d[0] = sliceRes[SLICE-1] ^ sliceOvf;
                        end
                    end else begin
                        carryOut_d = 1'b0;
                        overflow_d = 1'b0;
                    end
                    isZero_d = (result_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = result_q;
    assign carry_out = carryOut_q;
    assign overflow  = overflow_q;
    assign isZero    = isZero_q;

endmodule

// File: tb/tb_alu_serial_param.sv
// Self-checking bench for alu_serial_param (WIDTH=32, SLICE=8).
// Expected results are pushed to a scoreboard queue when an operation is
// issued and popped when the DUT presents its result.
module tb_alu_serial_param;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             Ainvert;
    logic             Binvert;
    logic [1:0]       Operation;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             overflow;
    logic             isZero;

    exp_t sbQueue[$];
    int   checksTotal  = 0;
    int   checksPassed = 0;

    alu_serial_param #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .operandA (operandA),
        .operandB (operandB),
        .Ainvert  (Ainvert),
        .Binvert  (Binvert),
        .Operation(Operation),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .carry_out(carry_out),
        .overflow (overflow),
        .isZero   (isZero)
    );

    always #5 clock = ~clock;

    // Whole-word reference: signed overflow from operand/result signs.
    function automatic exp_t modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic ai, input logic bi,
                                     input logic [1:0] op, input logic ci);
        logic [WIDTH-1:0] ae;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   s;
        logic             v;
        exp_t             e;
        ae = a ^ {WIDTH{ai}};
        be = b ^ {WIDTH{bi}};
        s  = {1'b0, ae} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        v  = (ae[WIDTH-1] == be[WIDTH-1]) && (s[WIDTH-1] != ae[WIDTH-1]);
        case (op)
            OP_AND:  e = '{ae & be, 1'b0, 1'b0, 1'b0};
            OP_OR:   e = '{ae | be, 1'b0, 1'b0, 1'b0};
            OP_ADD:  e = '{s[WIDTH-1:0], s[WIDTH], v, 1'b0};
            default: e = '{{{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ v}, s[WIDTH], v, 1'b0};
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic issueOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ai, input logic bi,
                           input logic [1:0] op, input logic ci, input exp_t e);
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        operandA  = a;
        operandB  = b;
        Ainvert   = ai;
        Binvert   = bi;
        Operation = op;
        carry_in  = ci;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        checksTotal++;
        if (in_ready !== 1'b1) $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
        else checksPassed++;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        operandA  = $urandom();
        operandB  = $urandom();
        Ainvert   = 1'($urandom_range(1));
        Binvert   = 1'($urandom_range(1));
        Operation = 2'($urandom_range(3));
        carry_in  = 1'($urandom_range(1));
        sbQueue.push_back(e);
    endtask

    // Counts edges after acceptance until out_valid is seen (bounded).
    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operandA  = '0;
        operandB  = '0;
        Ainvert   = 1'b0;
        Binvert   = 1'b0;
        Operation = OP_AND;
        carry_in  = 1'b0;
        #1;
        checksTotal++; if (out !== '0) $display("[TB] FAIL reset_out: got %h required 0", out); else checksPassed++;
        checksTotal++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); else checksPassed++;
        checksTotal++; if (carry_out !== 1'b0) $display("[TB] FAIL reset_carry_out: got %b required 0", carry_out); else checksPassed++;
        checksTotal++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b required 0", overflow); else checksPassed++;
        checksTotal++; if (isZero !== 1'b0) $display("[TB] FAIL reset_isZero: got %b required 0", isZero); else checksPassed++;
        repeat (2) @(posedge clock);
        #1;
        checksTotal++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); else checksPassed++;
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        checksTotal++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b required 1", in_ready); else checksPassed++;
    endtask

    task automatic test_add_sub();
        logic [WIDTH-1:0] aT[3];
        logic [WIDTH-1:0] bT[3];
        logic             biT[3];
        logic             ciT[3];
        exp_t             eT[3];
        exp_t             e;
        int               lat;
        aT  = '{32'h0000FFFF, 32'h80000000, 32'hFFFFFFFF};
        bT  = '{32'h00000001, 32'h00000001, 32'h00000001};
        biT = '{1'b0, 1'b1, 1'b0};
        ciT = '{1'b0, 1'b1, 1'b0};
        eT[0] = '{32'h00010000, 1'b0, 1'b0, 1'b0};
        eT[1] = '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        eT[2] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issueOp(aT[i], bT[i], 1'b0, biT[i], OP_ADD, ciT[i], eT[i]);
            waitDone(lat);
            e = sbQueue.pop_front();
            checksTotal++; if (out_valid !== 1'b1) $display("[TB] FAIL add_valid[%0d]: got %b required 1", i, out_valid); else checksPassed++;
            checksTotal++; if (lat !== N) $display("[TB] FAIL add_latency[%0d]: got %0d required %0d", i, lat, N); else checksPassed++;
            checksTotal++; if (out !== e.res) $display("[TB] FAIL add_out[%0d]: got %h required %h", i, out, e.res); else checksPassed++;
            checksTotal++; if (carry_out !== e.cout) $display("[TB] FAIL add_carry[%0d]: got %b required %b", i, carry_out, e.cout); else checksPassed++;
            checksTotal++; if (overflow !== e.ovf) $display("[TB] FAIL add_ovf[%0d]: got %b required %b", i, overflow, e.ovf); else checksPassed++;
            checksTotal++; if (isZero !== e.zero) $display("[TB] FAIL add_zero[%0d]: got %b required %b", i, isZero, e.zero); else checksPassed++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_slt();
        logic [WIDTH-1:0] aT[2];
        logic [WIDTH-1:0] bT[2];
        exp_t             eT[2];
        exp_t             e;
        int               lat;
        aT = '{32'hFFFFFFFF, 32'h7FFFFFFF};
        bT = '{32'h00000001, 32'h80000000};
        eT[0] = '{32'h00000001, 1'b1, 1'b0, 1'b0};
        eT[1] = '{32'h00000000, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            issueOp(aT[i], bT[i], 1'b0, 1'b1, OP_SLT, 1'b1, eT[i]);
            waitDone(lat);
            e = sbQueue.pop_front();
            checksTotal++; if (lat !== N) $display("[TB] FAIL slt_latency[%0d]: got %0d required %0d", i, lat, N); else checksPassed++;
            checksTotal++; if (out !== e.res) $display("[TB] FAIL slt_out[%0d]: got %h required %h", i, out, e.res); else checksPassed++;
            checksTotal++; if (carry_out !== e.cout) $display("[TB] FAIL slt_carry[%0d]: got %b required %b", i, carry_out, e.cout); else checksPassed++;
            checksTotal++; if (overflow !== e.ovf) $display("[TB] FAIL slt_ovf[%0d]: got %b required %b", i, overflow, e.ovf); else checksPassed++;
            checksTotal++; if (isZero !== e.zero) $display("[TB] FAIL slt_zero[%0d]: got %b required %b", i, isZero, e.zero); else checksPassed++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_logic();
        logic [WIDTH-1:0] aT[2];
        logic [WIDTH-1:0] bT[2];
        logic             aiT[2];
        logic [1:0]       opT[2];
        exp_t             eT[2];
        exp_t             e;
        int               lat;
        aT  = '{32'hF0F0F0F0, 32'h00FF0000};
        bT  = '{32'hFFFF0000, 32'h0000FF00};
        aiT = '{1'b1, 1'b0};
        opT = '{OP_AND, OP_OR};
        eT[0] = '{32'h0F0F0000, 1'b0, 1'b0, 1'b0};
        eT[1] = '{32'h00FFFF00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            // carry_in=1 must not leak into the logic-op flags
            issueOp(aT[i], bT[i], aiT[i], 1'b0, opT[i], 1'b1, eT[i]);
            waitDone(lat);
            e = sbQueue.pop_front();
            checksTotal++; if (lat !== N) $display("[TB] FAIL logic_latency[%0d]: got %0d required %0d", i, lat, N); else checksPassed++;
            checksTotal++; if (out !== e.res) $display("[TB] FAIL logic_out[%0d]: got %h required %h", i, out, e.res); else checksPassed++;
            checksTotal++; if (carry_out !== e.cout) $display("[TB] FAIL logic_carry[%0d]: got %b required %b", i, carry_out, e.cout); else checksPassed++;
            checksTotal++; if (overflow !== e.ovf) $display("[TB] FAIL logic_ovf[%0d]: got %b required %b", i, overflow, e.ovf); else checksPassed++;
            checksTotal++; if (isZero !== e.zero) $display("[TB] FAIL logic_zero[%0d]: got %b required %b", i, isZero, e.zero); else checksPassed++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        issueOp(32'h12345678, 32'h11111111, 1'b0, 1'b0, OP_ADD, 1'b0, '{32'h23456789, 1'b0, 1'b0, 1'b0});
        waitDone(lat);
        e = sbQueue.pop_front();
        checksTotal++; if (lat !== N) $display("[TB] FAIL bp_latency: got %0d required %0d", lat, N); else checksPassed++;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            operandA = $urandom();
            operandB = $urandom();
            @(posedge clock); #1;
            checksTotal++; if (out !== e.res) $display("[TB] FAIL bp_hold_out[%0d]: got %h required %h", c, out, e.res); else checksPassed++;
            checksTotal++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid[%0d]: got %b required 1", c, out_valid); else checksPassed++;
            checksTotal++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %b required 0", c, in_ready); else checksPassed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        checksTotal++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_in_ready: got %b required 1", in_ready); else checksPassed++;
        checksTotal++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b required 0", out_valid); else checksPassed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        issueOp(32'h12345678, 32'h00000001, 1'b0, 1'b0, OP_ADD, 1'b0, '{32'h12345679, 1'b0, 1'b0, 1'b0});
        // slices 0 and 1 computed; assert reset while slice 2 is in progress
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        void'(sbQueue.pop_front());
        #1;
        checksTotal++; if (out !== '0) $display("[TB] FAIL mid_reset_out: got %h required 0", out); else checksPassed++;
        checksTotal++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %b required 0", out_valid); else checksPassed++;
        checksTotal++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_reset_in_ready: got %b required 1", in_ready); else checksPassed++;
        checksTotal++; if ({carry_out, overflow, isZero} !== 3'b000) $display("[TB] FAIL mid_reset_flags: got %b required 000", {carry_out, overflow, isZero}); else checksPassed++;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        issueOp(32'd3, 32'd4, 1'b0, 1'b0, OP_ADD, 1'b0, '{32'd7, 1'b0, 1'b0, 1'b0});
        waitDone(lat);
        e = sbQueue.pop_front();
        checksTotal++; if (lat !== N) $display("[TB] FAIL post_reset_latency: got %0d required %0d", lat, N); else checksPassed++;
        checksTotal++; if (out !== e.res) $display("[TB] FAIL post_reset_out: got %h required %h", out, e.res); else checksPassed++;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ai;
        logic             bi;
        logic             ci;
        logic [1:0]       op;
        exp_t             e;
        int               lat;
        for (int i = 0; i < 8; i++) begin
            a  = $urandom();
            b  = (i == 3) ? a : $urandom();
            ai = 1'($urandom_range(1));
            bi = 1'($urandom_range(1));
            ci = 1'($urandom_range(1));
            op = 2'(i % 4);
            issueOp(a, b, ai, bi, op, ci, modelOp(a, b, ai, bi, op, ci));
            waitDone(lat);
            e = sbQueue.pop_front();
            checksTotal++; if (lat !== N) $display("[TB] FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, N); else checksPassed++;
            checksTotal++; if (out !== e.res) $display("[TB] FAIL b2b_out[%0d]: got %h required %h", i, out, e.res); else checksPassed++;
            checksTotal++; if ({carry_out, overflow, isZero} !== {e.cout, e.ovf, e.zero}) $display("[TB] FAIL b2b_flags[%0d]: got %b required %b", i, {carry_out, overflow, isZero}, {e.cout, e.ovf, e.zero}); else checksPassed++;
            @(posedge clock); #1;
            checksTotal++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready[%0d]: got %b required 1", i, in_ready); else checksPassed++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt();
        test_logic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
